// File: rtl/star_pkg.sv
// Shared types and constants for the STAR row scheduler.
// Combinational definitions only; no latency.
// No flow control lives here.
package star_pkg;

    localparam int STAR_ADDR_W = 9;
    localparam int STAR_ROWS_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT = 2'b01;
    localparam logic [1:0] STAT_EMPTY   = 2'b10;

    // Job descriptor as stored in the FIFO (14 bits).
    typedef struct packed {
        logic [STAR_ADDR_W-1:0] base;
        logic [STAR_ROWS_W-1:0] rows;
    } job_t;

    localparam int JOB_W = $bits(job_t);

endpackage

// File: rtl/star_sched_fifo.sv
// Generic descriptor FIFO with full/empty flags and show-ahead read data.
// Latency: a push is visible at pop_dat on the cycle after the write.
// Backpressure: pushes are dropped while full; pops are ignored while empty.
// Ports: clk, rst_n (async active-low), push_vld/push_dat, pop_vld,
//        pop_dat (head entry), full, empty.
module star_sched_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_vld && !full;
    assign w_pop  = pop_vld && !empty;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/star_row_sched.sv
// Queues job descriptors and launches the STAR engine once per row, then reports completion.
// Latency: job into empty FIFO while idle -> eng_start 3 cycles later; eng_finish -> next eng_start 2 cycles.
// Backpressure: job_ready drops when the FIFO is full; REPORT holds until done_ready.
// Ports: clk, reset (async active-low), job_valid/job_ready/job_base/job_rows,
//        eng_start/eng_base/eng_finish, done_valid/done_ready/done_rows/done_status, busy.
// Optional macro STAR_SCHED_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYC cycles.
module star_row_sched
    import star_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ROW_LEN     = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [STAR_ADDR_W-1:0] job_base,
    input  logic [STAR_ROWS_W-1:0] job_rows,
    output logic                   eng_start,
    output logic [STAR_ADDR_W-1:0] eng_base,
    input  logic                   eng_finish,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [STAR_ROWS_W-1:0] done_rows,
    output logic [1:0]             done_status,
    output logic                   busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("star_row_sched: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
        $error("star_row_sched: TIMEOUT_CYC must be >= 1");
    end

    localparam logic [STAR_ADDR_W-1:0] ROW_STRIDE = STAR_ADDR_W'(ROW_LEN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STAR_ROWS_W-1:0] r_rows;
    logic [STAR_ROWS_W-1:0] r_row_idx;
    logic [STAR_ROWS_W-1:0] w_row_inc;
    logic [STAR_ADDR_W-1:0] r_eng_base;
    logic [STAR_ROWS_W-1:0] r_done_rows;
    logic [1:0]             r_done_status;
    logic                   r_fin;
    logic                   w_tmo;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    job_t                   w_job_in;
    job_t                   w_job;

    assign w_job_in = '{base: job_base, rows: job_rows};

    star_sched_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (job_valid),
        .push_dat (w_job_in),
        .pop_vld  (w_pop),
        .pop_dat  (w_job),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    assign w_row_inc = r_row_idx + 1'b1;

    // Finish strobe is registered once; this stage is what puts the next
    // launch two cycles after the finish. The !r_fin term stops a finish held
    // for two cycles from counting twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fin <= 1'b0;
        else        r_fin <= (r_state == ST_WAIT) && eng_finish && !r_fin;
    end

`ifdef STAR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    r_tmo_cnt <= '0;
        else if (r_state != ST_WAIT)   r_tmo_cnt <= '0;
        else if (!r_fin)               r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    // A finish arriving on the last allowed cycle is honoured one cycle later
    // through r_fin, so the timeout backs off when eng_finish is high.
    assign w_tmo = (r_state == ST_WAIT) && (r_tmo_cnt == TMO_LAST) && !r_fin && !eng_finish;
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_IDLE:   if (!w_fifo_empty) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = (w_job.rows == '0) ? ST_REPORT : ST_LAUNCH;
            end
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_fin)      w_state_nxt = (w_row_inc == r_rows) ? ST_REPORT : ST_LAUNCH;
                else if (w_tmo) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: if (done_ready) w_state_nxt = w_fifo_empty ? ST_IDLE : ST_LOAD;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_rows        <= '0;
            r_row_idx     <= '0;
            r_eng_base    <= '0;
            r_done_rows   <= '0;
            r_done_status <= STAT_OK;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOAD) begin
                r_rows     <= w_job.rows;
                r_row_idx  <= '0;
                r_eng_base <= w_job.base;
                if (w_job.rows == '0) begin
                    r_done_rows   <= '0;
                    r_done_status <= STAT_EMPTY;
                end
            end else if (r_state == ST_WAIT) begin
                if (r_fin) begin
                    r_row_idx <= w_row_inc;
                    if (w_row_inc == r_rows) begin
                        r_done_rows   <= w_row_inc;
                        r_done_status <= STAT_OK;
                    end else begin
                        // Base advances only after the finish, so it stays put
                        // for the whole row; 9-bit addition wraps mod 512.
                        r_eng_base <= r_eng_base + ROW_STRIDE;
                    end
                end else if (w_tmo) begin
                    r_done_rows   <= r_row_idx;
                    r_done_status <= STAT_TIMEOUT;
                end
            end
        end
    end

    assign job_ready   = !w_fifo_full;
    assign eng_start   = (r_state == ST_LAUNCH);
    assign eng_base    = r_eng_base;
    assign done_valid  = (r_state == ST_REPORT);
    assign done_rows   = r_done_rows;
    assign done_status = r_done_status;
    assign busy        = (r_state != ST_IDLE);

endmodule
